timer_unit: RTL and testbench

Parametrised, bus-programmable timer peripheral for the CPU's memory-mapped I/O space and the successor to the fixed one-second counter. It divides `clk` through a programmable prescaler, advances a WIDTH-bit count on each prescaler tick, and compares the count against a programmable compare value. Counting can be free-running, auto-reload or one-shot, and a sticky match flag drives a maskable interrupt. The bus side uses the same zero-wait STB/ACK handshake as the existing peripherals, extended with write and address lines.

---
 rtl/timer_unit.sv | 154 +++++++++++++++
 tb/tb_timer_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_unit.sv
// timer_unit: bus-programmable timer with a prescaler, a WIDTH-bit count and a
// compare register. Supports free-running, auto-reload and one-shot modes, and a
// sticky match flag that drives a maskable interrupt. Zero-wait STB/ACK bus.
module timer_unit #(
  parameter int          WIDTH          = 32,
  parameter logic [31:0] PRESCALE_RESET = 32'd1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        STB,
  input  logic        WE,
  input  logic [1:0]  ADR,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK,
  output logic        IRQ
);

  localparam logic [1:0] ADR_COUNT    = 2'd0;
  localparam logic [1:0] ADR_PRESCALE = 2'd1;
  localparam logic [1:0] ADR_COMPARE  = 2'd2;
  localparam logic [1:0] ADR_CTRL     = 2'd3;

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] compare_q, compare_d;
  logic [31:0]      prescale_q, prescale_d;
  logic [31:0]      pcnt_q, pcnt_d;
  logic             en_q, en_d;
  logic             reload_q, reload_d;
  logic             oneshot_q, oneshot_d;
  logic             ie_q, ie_d;
  logic             flag_q, flag_d;

  logic wr_any;
  logic wr_count;
  logic wr_prescale;
  logic wr_compare;
  logic wr_ctrl;
  logic tick;
  logic match;

  assign wr_any      = STB & WE;
  assign wr_count    = wr_any && (ADR == ADR_COUNT);
  assign wr_prescale = wr_any && (ADR == ADR_PRESCALE);
  assign wr_compare  = wr_any && (ADR == ADR_COMPARE);
  assign wr_ctrl     = wr_any && (ADR == ADR_CTRL);

  // The prescaler only runs while enabled; a tick is the cycle where it wraps.
  assign tick  = en_q && (pcnt_q == prescale_q);
  // A software COUNT write in the tick cycle suppresses that cycle's match.
  // COMPARE writes land at the edge, so the match naturally uses the old value.
  assign match = tick && (count_q == compare_q) && !wr_count;

  // Next-state logic: bus writes, prescaler, count modes and the sticky flag.
  always_comb begin
    pcnt_d     = pcnt_q;
    count_d    = count_q;
    prescale_d = prescale_q;
    compare_d  = compare_q;
    en_d       = en_q;
    reload_d   = reload_q;
    oneshot_d  = oneshot_q;
    ie_d       = ie_q;
    flag_d     = flag_q;

    // A PRESCALE write restarts the prescale period from zero.
    if (wr_prescale) begin
      pcnt_d = '0;
    end else if (tick) begin
      pcnt_d = '0;
    end else if (en_q) begin
      pcnt_d = pcnt_q + 32'd1;
    end

    // One-shot holds the count on a match; reload restarts; otherwise wrap-around.
    if (wr_count) begin
      count_d = DAT_I[WIDTH-1:0];
    end else if (tick) begin
      if (match && oneshot_q) begin
        count_d = count_q;
      end else if (match && reload_q) begin
        count_d = '0;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end

    if (wr_prescale) begin
      prescale_d = DAT_I;
    end
    if (wr_compare) begin
      compare_d = DAT_I[WIDTH-1:0];
    end

    // A software EN write overrides the one-shot auto-disable in the same cycle.
    if (wr_ctrl) begin
      en_d      = DAT_I[0];
      reload_d  = DAT_I[1];
      oneshot_d = DAT_I[2];
      ie_d      = DAT_I[3];
    end else if (match && oneshot_q) begin
      en_d = 1'b0;
    end

    // Setting beats a simultaneous write-1-to-clear so no match is ever lost.
    if (match) begin
      flag_d = 1'b1;
    end else if (wr_ctrl && DAT_I[4]) begin
      flag_d = 1'b0;
    end
  end

  // State registers; reset leaves the block counting like the legacy timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      pcnt_q     <= '0;
      prescale_q <= PRESCALE_RESET;
      compare_q  <= '1;
      en_q       <= 1'b1;
      reload_q   <= 1'b0;
      oneshot_q  <= 1'b0;
      ie_q       <= 1'b0;
      flag_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      pcnt_q     <= pcnt_d;
      prescale_q <= prescale_d;
      compare_q  <= compare_d;
      en_q       <= en_d;
      reload_q   <= reload_d;
      oneshot_q  <= oneshot_d;
      ie_q       <= ie_d;
      flag_q     <= flag_d;
    end
  end

  // Zero-wait read mux; the bus sees zero whenever the block is not selected.
  always_comb begin
    DAT_O = '0;
    if (STB) begin
      case (ADR)
        ADR_COUNT:    DAT_O = 32'(count_q);
        ADR_PRESCALE: DAT_O = prescale_q;
        ADR_COMPARE:  DAT_O = 32'(compare_q);
        default:      DAT_O = {27'd0, flag_q, ie_q, oneshot_q, reload_q, en_q};
      endcase
    end
  end

  assign ACK = STB;
  assign IRQ = flag_q & ie_q;

endmodule

// File: tb/tb_timer_unit.sv
// tb_timer_unit: directed test of timer_unit (WIDTH=8, PRESCALE_RESET=3) against a
// behavioural model, with literal expectations for the key scenarios.
module tb_timer_unit;

  localparam int MOD = 256;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        STB   = 1'b0;
  logic        WE    = 1'b0;
  logic [1:0]  ADR   = 2'd0;
  logic [31:0] DAT_I = 32'd0;
  logic [31:0] DAT_O;
  logic        ACK;
  logic        IRQ;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  timer_unit #(.WIDTH(8), .PRESCALE_RESET(32'd3)) dut (
    .clk   (clk),
    .reset (reset),
    .STB   (STB),
    .WE    (WE),
    .ADR   (ADR),
    .DAT_I (DAT_I),
    .DAT_O (DAT_O),
    .ACK   (ACK),
    .IRQ   (IRQ)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          m_count;
  int          m_cmp;
  logic [31:0] m_pcnt;
  logic [31:0] m_presc;
  logic        m_en, m_rel, m_os, m_ie, m_flag;

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_count);
      2'd1:    return m_presc;
      2'd2:    return 32'(m_cmp);
      default: return {27'd0, m_flag, m_ie, m_os, m_rel, m_en};
    endcase
  endfunction

  // Model of the timer state, advanced once per clock edge.
  always @(posedge clk or posedge reset) begin : model
    logic tk, hit, wc, wctl;
    if (reset) begin
      m_count <= 0;
      m_pcnt  <= 32'd0;
      m_presc <= 32'd3;
      m_cmp   <= MOD - 1;
      m_en    <= 1'b1;
      m_rel   <= 1'b0;
      m_os    <= 1'b0;
      m_ie    <= 1'b0;
      m_flag  <= 1'b0;
    end else begin
      wc   = STB && WE && (ADR == 2'd0);
      wctl = STB && WE && (ADR == 2'd3);
      tk   = m_en && (m_pcnt == m_presc);
      hit  = tk && !wc && (m_count == m_cmp);
      if (STB && WE && ADR == 2'd1) m_pcnt <= 32'd0;
      else if (m_en) m_pcnt <= tk ? 32'd0 : m_pcnt + 32'd1;
      if (STB && WE && ADR == 2'd1) m_presc <= DAT_I;
      if (STB && WE && ADR == 2'd2) m_cmp <= int'(DAT_I[7:0]);
      if (wc) m_count <= int'(DAT_I[7:0]);
      else if (tk && !(hit && m_os)) m_count <= (hit && m_rel) ? 0 : (m_count + 1) % MOD;
      if (wctl) begin
        m_en  <= DAT_I[0];
        m_rel <= DAT_I[1];
        m_os  <= DAT_I[2];
        m_ie  <= DAT_I[3];
      end else if (hit && m_os) begin
        m_en <= 1'b0;
      end
      if (hit) m_flag <= 1'b1;
      else if (wctl && DAT_I[4]) m_flag <= 1'b0;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Per-cycle comparison of the bus outputs and IRQ against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_ack", {31'd0, ACK}, {31'd0, STB});
      check("cyc_irq", {31'd0, IRQ}, {31'd0, m_flag & m_ie});
      check("cyc_dat_o", DAT_O, STB ? m_read(ADR) : 32'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    STB = 1'b1; WE = 1'b1; ADR = a; DAT_I = d;
    cyc();
    STB = 1'b0; WE = 1'b0; DAT_I = 32'd0;
    $display("write adr=%0d data=0x%08h", a, d);
  endtask

  task automatic peek(input logic [1:0] a, input logic [31:0] exp, input string nm);
    STB = 1'b1; WE = 1'b0; ADR = a;
    #1;
    check(nm, DAT_O, exp);
    check({nm, "_model"}, DAT_O, m_read(a));
    $display("read  adr=%0d data=0x%08h (%s)", a, DAT_O, nm);
    STB = 1'b0;
  endtask

  task automatic idle_bus(input int k);
    STB = 1'b1; WE = 1'b0; ADR = 2'(k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    // Reset values
    peek(2'd3, 32'h1, "rst_ctrl");
    peek(2'd0, 32'h0, "rst_count");
    peek(2'd1, 32'h3, "rst_presc");
    cyc();
    peek(2'd2, 32'hFF, "rst_cmp");
    check("rst_irq", {31'd0, IRQ}, 32'd0);
    reset = 1'b0;

    // Default free-running count: tick every 4 cycles, wrap at 255 sets FLAG
    for (int k = 1; k <= 1024; k++) begin
      cyc();
      if (k == 3)    peek(2'd0, 32'd0, "free_k3");
      if (k == 4)    peek(2'd0, 32'd1, "free_k4");
      if (k == 7)    peek(2'd0, 32'd1, "free_k7");
      if (k == 11)   peek(2'd0, 32'd2, "free_k11");
      if (k == 1020) peek(2'd0, 32'd255, "free_k1020");
      if (k == 1023) peek(2'd3, 32'h01, "free_ctrl_prewrap");
      if (k == 1024) begin
        peek(2'd0, 32'd0, "free_wrap");
        peek(2'd3, 32'h11, "free_flag");
      end
      idle_bus(k);
    end
    STB = 1'b0;

    // Reload mode with PRESCALE=0, COMPARE=4, IRQ enabled
    wr(2'd3, 32'h10);
    wr(2'd1, 32'd0);
    wr(2'd2, 32'd4);
    wr(2'd0, 32'd0);
    wr(2'd3, 32'h0B);
    peek(2'd0, 32'd0, "rel_j0");
    for (int j = 1; j <= 7; j++) begin
      cyc();
      peek(2'd0, 32'(j % 5), "rel_count");
      if (j == 4) check("rel_irq_low", {31'd0, IRQ}, 32'd0);
      if (j == 5) check("rel_irq_high", {31'd0, IRQ}, 32'd1);
    end
    wr(2'd3, 32'h1A);
    check("w1c_irq", {31'd0, IRQ}, 32'd0);
    peek(2'd3, 32'h0A, "w1c_ctrl");
    peek(2'd0, 32'd3, "w1c_count");

    // One-shot with PRESCALE=1, COMPARE=3
    wr(2'd1, 32'd1);
    wr(2'd2, 32'd3);
    wr(2'd0, 32'd0);
    wr(2'd3, 32'h05);
    for (int j = 1; j <= 10; j++) begin
      cyc();
      peek(2'd0, 32'((j / 2 < 3) ? j / 2 : 3), "os_count");
      if (j == 7) peek(2'd3, 32'h05, "os_ctrl_run");
      if (j == 8) peek(2'd3, 32'h14, "os_ctrl_done");
    end
    wr(2'd3, 32'h01);
    peek(2'd3, 32'h11, "os_reen_ctrl");
    cyc();
    peek(2'd0, 32'd3, "os_reen_1");
    cyc();
    peek(2'd0, 32'd4, "os_reen_2");
    // Pause mid-prescale, then resume from the held prescaler value
    wr(2'd3, 32'h00);
    repeat (3) cyc();
    peek(2'd0, 32'd4, "pause_hold");
    wr(2'd3, 32'h01);
    cyc();
    peek(2'd0, 32'd5, "resume_held_pcnt");

    // Conflict: COUNT write coinciding with a tick that would match
    wr(2'd3, 32'h10);
    wr(2'd1, 32'd0);
    wr(2'd0, 32'd5);
    wr(2'd2, 32'd5);
    wr(2'd3, 32'h01);
    wr(2'd0, 32'h10);
    peek(2'd0, 32'h10, "cf_count_wr");
    peek(2'd3, 32'h01, "cf_no_match");
    // Conflict: FLAG clear coinciding with a match
    wr(2'd3, 32'h10);
    wr(2'd2, 32'h20);
    wr(2'd0, 32'h20);
    wr(2'd3, 32'h01);
    wr(2'd3, 32'h11);
    peek(2'd3, 32'h11, "cf_flag_set_wins");
    peek(2'd0, 32'h21, "cf_flag_count");
    // PRESCALE write clears PCNT
    wr(2'd3, 32'h10);
    wr(2'd1, 32'd3);
    wr(2'd0, 32'd0);
    wr(2'd3, 32'h01);
    cyc();
    cyc();
    wr(2'd1, 32'd3);
    cyc();
    peek(2'd0, 32'd0, "pcnt_clr_1");
    cyc();
    cyc();
    cyc();
    peek(2'd0, 32'd1, "pcnt_clr_4");

    // Bus behaviour
    wr(2'd3, 32'h10);
    wr(2'd0, 32'hFFFF_FF7F);
    peek(2'd0, 32'h7F, "bus_trunc");
    STB = 1'b0; ADR = 2'd0;
    #1;
    check("bus_idle_dat", DAT_O, 32'd0);
    check("bus_idle_ack", {31'd0, ACK}, 32'd0);
    wr(2'd1, 32'h8000_0003);
    peek(2'd1, 32'h8000_0003, "bus_presc32");

    // Asynchronous reset mid-prescale with IRQ asserted
    wr(2'd1, 32'd3);
    wr(2'd2, 32'd0);
    wr(2'd0, 32'd0);
    wr(2'd3, 32'h09);
    repeat (4) cyc();
    check("ar_irq_before", {31'd0, IRQ}, 32'd1);
    peek(2'd3, 32'h19, "ar_ctrl_before");
    cyc();
    cyc();
    STB = 1'b1; WE = 1'b0; ADR = 2'd0;
    #1;
    check("ar_count_before", DAT_O, 32'd1);
    reset = 1'b1;
    #1;
    check("ar_irq", {31'd0, IRQ}, 32'd0);
    check("ar_dat_o", DAT_O, 32'd0);
    STB = 1'b0;
    peek(2'd3, 32'h1, "ar_ctrl");
    peek(2'd1, 32'h3, "ar_presc");
    peek(2'd2, 32'hFF, "ar_cmp");
    cyc();
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      if (k == 3) peek(2'd0, 32'd0, "ar_resume_3");
      if (k == 4) peek(2'd0, 32'd1, "ar_resume_4");
    end

    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
